// File: rtl/sseg_pkg.sv
// Shared constants for the stopwatch display source: segment patterns,
// decimal-point levels and per-digit counting limits.
package sseg_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [3:0] digit_t;

  // Active-low g..a patterns for 0..9, index = digit value
  localparam logic [9:0][6:0] SEG_PAT = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic DP_ON  = 1'b0;
  localparam logic DP_OFF = 1'b1;

  // Display reads M.SS.t, so the dot is lit after minutes and seconds units
  localparam logic [NUM_DIGITS-1:0] DIGIT_DP = {DP_ON, DP_OFF, DP_ON, DP_OFF};

  // Wrap value per digit: tenths, sec units, sec tens, minutes
  localparam logic [NUM_DIGITS-1:0][3:0] DIGIT_MAX = {4'd9, 4'd5, 4'd9, 4'd9};

endpackage

// File: rtl/bcd_to_sseg.sv
// One BCD digit to an active-low 7-segment pattern with decimal point.
module bcd_to_sseg
  import sseg_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       dp,
  output logic [7:0] seg
);

  always_comb begin
    seg = {dp, SEG_BLANK};
    if (digit <= 4'd9) seg[6:0] = SEG_PAT[digit];
  end

endmodule

// File: rtl/sseg_stopwatch_src.sv
// Stopwatch time source: tick divider plus M.SS.t BCD counter chain,
// counting up or down, decoded into four active-low digit patterns.
module sseg_stopwatch_src
  import sseg_pkg::*;
#(
  parameter int CLK_HZ   = 100_000_000,
  parameter int TICK_DIV = CLK_HZ / 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  input  logic       clr,
  input  logic       up,
  output logic [7:0] in0,
  output logic [7:0] in1,
  output logic [7:0] in2,
  output logic [7:0] in3,
  output logic       rollover
);

  localparam int DIV_W = $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0]               div_q;
  logic [NUM_DIGITS-1:0][3:0]     dig_q, dig_d;
  logic [NUM_DIGITS-1:0][7:0]     segs;
  logic                           tick;
  logic                           cy;
  logic                           wrap;

  assign tick = go & ~clr & (div_q == DIV_LAST);

  // Ripple carry/borrow through the chain; carry out of the top is the wrap
  always_comb begin
    dig_d = dig_q;
    cy    = tick;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (cy) begin
        if (up) begin
          if (dig_q[i] >= DIGIT_MAX[i]) begin
            dig_d[i] = 4'd0;
          end else begin
            dig_d[i] = dig_q[i] + 4'd1;
            cy       = 1'b0;
          end
        end else begin
          if (dig_q[i] == 4'd0) begin
            dig_d[i] = DIGIT_MAX[i];
          end else begin
            dig_d[i] = dig_q[i] - 4'd1;
            cy       = 1'b0;
          end
        end
      end
    end
    wrap = cy;
  end

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      div_q    <= '0;
      dig_q    <= '0;
      rollover <= 1'b0;
    end else begin
      if (go) div_q <= tick ? '0 : div_q + DIV_W'(1);
      dig_q    <= dig_d;
      rollover <= wrap;
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    bcd_to_sseg u_dec (
      .digit (dig_q[g]),
      .dp    (DIGIT_DP[g]),
      .seg   (segs[g])
    );
  end

  assign in0 = segs[0];
  assign in1 = segs[1];
  assign in2 = segs[2];
  assign in3 = segs[3];

endmodule

// File: tb/tb_sseg_stopwatch_src.sv
// Directed bench for sseg_stopwatch_src with TICK_DIV=4: a vector table
// followed by hand-written wrap, pause, clear and reset sequences.
module tb_sseg_stopwatch_src;

  logic       clk = 1'b0;
  logic       reset, go, clr, up;
  logic [7:0] in0, in1, in2, in3;
  logic       rollover;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sseg_stopwatch_src #(.CLK_HZ(40), .TICK_DIV(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .go       (go),
    .clr      (clr),
    .up       (up),
    .in0      (in0),
    .in1      (in1),
    .in2      (in2),
    .in3      (in3),
    .rollover (rollover)
  );

  typedef struct {
    logic       rst, go, clr, up;
    int         ncyc;
    logic [7:0] e0, e1, e2, e3;
    logic       ero;
  } vec_t;

  vec_t vt[8];

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] e0, e1, e2, e3,
                     input logic er);
    n_cmp++;
    if ({in0, in1, in2, in3, rollover} !== {e0, e1, e2, e3, er}) begin
      n_bad++;
      $display("FAIL %s: got in0..3=%h %h %h %h ro=%b, want %h %h %h %h ro=%b",
               name, in0, in1, in2, in3, rollover, e0, e1, e2, e3, er);
    end
  endtask

  initial begin
    reset = 1'b1; go = 1'b0; clr = 1'b0; up = 1'b1;

    //        rst  go   clr  up  ncyc  in0    in1    in2    in3    ro
    vt[0] = '{1'b1,1'b0,1'b0,1'b1, 1, 8'hC0, 8'h40, 8'hC0, 8'h40, 1'b0}; // reset state
    vt[1] = '{1'b0,1'b1,1'b0,1'b1,40, 8'hC0, 8'h79, 8'hC0, 8'h40, 1'b0}; // 10 ticks -> 0.01.0
    vt[2] = '{1'b0,1'b1,1'b0,1'b1, 4, 8'hF9, 8'h79, 8'hC0, 8'h40, 1'b0}; // 0.01.1
    vt[3] = '{1'b0,1'b0,1'b0,1'b1,10, 8'hF9, 8'h79, 8'hC0, 8'h40, 1'b0}; // paused
    vt[4] = '{1'b0,1'b1,1'b0,1'b0, 4, 8'hC0, 8'h79, 8'hC0, 8'h40, 1'b0}; // down -> 0.01.0
    vt[5] = '{1'b0,1'b1,1'b1,1'b0, 1, 8'hC0, 8'h40, 8'hC0, 8'h40, 1'b0}; // clear
    vt[6] = '{1'b0,1'b1,1'b0,1'b0, 4, 8'h90, 8'h10, 8'h92, 8'h10, 1'b1}; // down wrap 9.59.9
    vt[7] = '{1'b0,1'b1,1'b0,1'b0, 1, 8'h90, 8'h10, 8'h92, 8'h10, 1'b0}; // pulse gone

    for (int i = 0; i < 8; i++) begin
      reset = vt[i].rst; go = vt[i].go; clr = vt[i].clr; up = vt[i].up;
      step(vt[i].ncyc);
      chk($sformatf("vec%0d", i), vt[i].e0, vt[i].e1, vt[i].e2, vt[i].e3, vt[i].ero);
    end

    // Count up from reset through 5999 ticks, then wrap
    reset = 1'b1; go = 1'b0; clr = 1'b0; up = 1'b1;
    step(1);
    reset = 1'b0; go = 1'b1;
    step(4 * 5999);
    chk("up_preload", 8'h90, 8'h10, 8'h92, 8'h10, 1'b0);
    step(4);
    chk("up_wrap", 8'hC0, 8'h40, 8'hC0, 8'h40, 1'b1);
    step(1);
    chk("up_wrap_pulse_end", 8'hC0, 8'h40, 8'hC0, 8'h40, 1'b0);

    // Pause mid-period: resume finishes the remaining divider count
    clr = 1'b1; step(1); clr = 1'b0;
    step(4);
    chk("pause_pre", 8'hF9, 8'h40, 8'hC0, 8'h40, 1'b0);
    step(2);
    go = 1'b0;
    step(10);
    chk("pause_hold", 8'hF9, 8'h40, 8'hC0, 8'h40, 1'b0);
    go = 1'b1;
    step(1);
    chk("pause_resume_1", 8'hF9, 8'h40, 8'hC0, 8'h40, 1'b0);
    step(1);
    chk("pause_resume_2", 8'hA4, 8'h40, 8'hC0, 8'h40, 1'b0);

    // clr in the tick cycle: clears instead of incrementing, divider restarts
    step(3);
    clr = 1'b1;
    step(1);
    chk("clr_at_tick", 8'hC0, 8'h40, 8'hC0, 8'h40, 1'b0);
    clr = 1'b0;
    step(3);
    chk("clr_div_restart", 8'hC0, 8'h40, 8'hC0, 8'h40, 1'b0);
    step(1);
    chk("clr_first_tick", 8'hF9, 8'h40, 8'hC0, 8'h40, 1'b0);

    // reset in the tick cycle: pending tick dropped, full latency afterwards
    step(3);
    reset = 1'b1;
    step(1);
    chk("reset_at_tick", 8'hC0, 8'h40, 8'hC0, 8'h40, 1'b0);
    reset = 1'b0;
    step(3);
    chk("reset_latency", 8'hC0, 8'h40, 8'hC0, 8'h40, 1'b0);
    step(1);
    chk("reset_first_tick", 8'hF9, 8'h40, 8'hC0, 8'h40, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sseg_stopwatch_src.md
SSEG_STOPWATCH_SRC -- requirements
Module: sseg_stopwatch_src

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 100_000_000, meaning the input clock frequency in Hz.
REQ-002 The block SHALL have parameter TICK_DIV, default CLK_HZ/10, meaning the clocks per 0.1 s count tick (minimum 2).
REQ-003 The block SHALL have port clk, input, 1, the single system clock.
REQ-004 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port go, input, 1, level-sensitive: 1 = counting enabled, 0 = paused.
REQ-006 The block SHALL have port clr, input, 1, level-sensitive synchronous clear of time and divider.
REQ-007 The block SHALL have port up, input, 1, direction: 1 = count up, 0 = count down.
REQ-008 The block SHALL have ports in0..in3, output, 8 each, active-low segment patterns for digits 0..3 (bit7 = dp, bits6:0 = g..a), consumed directly by the 4-digit time multiplexer.
REQ-009 The block SHALL have port rollover, output, 1, one-cycle pulse on wrap in either direction.

Function
REQ-010 Time SHALL be held as four BCD registers: d0 tenths (0-9), d1 seconds units (0-9), d2 seconds tens (0-5), d3 minutes (0-9); the display reads M.SS.t.
REQ-011 The divider SHALL count 0..TICK_DIV-1 only while go=1 and clr=0, and hold its value while go=0.
REQ-012 tick SHALL be internal, asserted in the cycle where divider = TICK_DIV-1 and go=1 and clr=0; the divider SHALL return to 0 on the following edge.
REQ-013 On tick with up=1, d0 SHALL increment, with carry into d1 at 9, into d2 at 9, into d3 at 5; 9.59.9 SHALL wrap to 0.00.0.
REQ-014 On tick with up=0, d0 SHALL decrement, with borrow from d1 at 0, d2 reloading 5, d3 reloading 9; 0.00.0 SHALL wrap to 9.59.9.
REQ-015 Digit registers SHALL update on the clock edge ending the tick cycle; in0..in3 SHALL be combinational decodes of the digit registers, so the new pattern is visible exactly 1 cycle after tick.
REQ-016 rollover SHALL be registered and high for exactly the one cycle in which the wrapped value is first visible.
REQ-017 clr SHALL take priority over go and tick: on the next edge, digits = 0, divider = 0, and rollover = 0.
REQ-018 A change of up SHALL take effect on the next tick without disturbing the divider phase.
REQ-019 Decode SHALL use segment bits 6:0 for 0=C0,1=F9,2=A4,3=B0,4=99,5=92,6=82,7=F8,8=80,9=90 (hex, dp off); in1 and in3 SHALL drive dp=0 (lit), and in0 and in2 SHALL drive dp=1.
REQ-020 Any digit register value outside 0-9 SHALL decode to all segments off (bits6:0 = 1).

Reset
REQ-021 reset SHALL be synchronous and active-high, with priority over clr, go, and tick.
REQ-022 After reset: divider=0, d0..d3=0, rollover=0, in0=C0, in1=40, in2=C0, in3=40 (hex).
REQ-023 Reset asserted mid-count SHALL discard a pending tick, and the count SHALL restart from 0.00.0 with full TICK_DIV latency after deassertion and go=1.

Structure
REQ-024 Package sseg_pkg SHALL hold the digit-pattern constants, the DP_ON/DP_OFF constants, and the per-digit maxima (9,9,5,9).
REQ-025 One combinational sub-module, bcd_to_sseg (4-bit digit plus dp in, 8-bit active-low pattern out), SHALL be instantiated four times.
REQ-026 The divider and BCD counter chain SHALL reside in the top module; no other sub-modules SHALL exist.

Verification (TICK_DIV=4 in the bench)
REQ-027 Reset then go=1, up=1, 40 cycles -> 10 ticks; the display reads 0.01.0, i.e. in0=C0, in1=79, in2=C0, in3=40.
REQ-028 Preload via ticks to 9.59.9, then one more tick -> 0.00.0 with rollover=1 for exactly 1 cycle, coincident with in3=40, in2=C0.
REQ-029 From reset, up=0, one tick -> 9.59.9 (in0=90, in1=10, in2=92, in3=10) with rollover=1 for 1 cycle.
REQ-030 Counting, go=0 for 10 cycles, then go=1 -> digits frozen during the pause; the next tick arrives after the remaining divider count, not the full TICK_DIV.
REQ-031 clr=1 and go=1 asserted in the same cycle as tick -> next edge digits=0, divider=0, rollover=0, with no increment applied.
REQ-032 reset asserted one cycle before a tick -> no digit change, and the outputs equal the REQ-022 values.
